// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out converter, valid/ready handshake on both sides.
// Latency: the first slice of a word is on OUT the cycle after its IN fire; back-to-back words emit with no bubble.
// Backpressure: OUT_READY low freezes the shifter; the one-entry holding buffer absorbs one more word, then IN_READY drops.
//
// Ports:
//   CLK, RESET_N                    clock (rising edge), asynchronous active-low reset
//   IN_VALID/IN_READY               input handshake; IN_READY depends on registers only
//   IN_DATA, IN_NUM, IN_LAST        parallel word, slice count minus one, packet-closing flag
//   OUT_VALID/OUT_READY             output handshake
//   OUT_DATA, OUT_LAST              current slice (zero when idle), last slice of a LAST word
module piso_stream #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16,
  parameter bit MSB_FIRST      = 1'b0,
  localparam int NUM_WORDS     = DATA_IN_WIDTH / DATA_OUT_WIDTH,
  localparam int CNT_W         = $clog2(NUM_WORDS)
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_IN_WIDTH-1:0]  IN_DATA,
  input  logic [CNT_W-1:0]          IN_NUM,
  input  logic                      IN_LAST,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_OUT_WIDTH-1:0] OUT_DATA,
  output logic                      OUT_LAST
);

  generate
    if ((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0 || NUM_WORDS < 2) begin : g_bad_params
      $error("piso_stream: DATA_IN_WIDTH must be a multiple (>=2x) of DATA_OUT_WIDTH");
    end
  endgenerate

  // Shifter: the word currently being emitted.
  logic [DATA_IN_WIDTH-1:0]  sh_data;
  logic [CNT_W-1:0]          sh_rem;     // slices still to come after the current one
  logic                      sh_last;
  logic                      sh_valid;

  // Holding buffer: one word accepted while the shifter is busy.
  logic [DATA_IN_WIDTH-1:0]  hb_data;
  logic [CNT_W-1:0]          hb_num;
  logic                      hb_last;
  logic                      hb_valid;

  logic                      in_fire;
  logic                      out_fire;
  logic                      sh_done;
  logic                      free;
  logic [DATA_OUT_WIDTH-1:0] cur_slice;
  logic [DATA_IN_WIDTH-1:0]  sh_shifted;

  assign IN_READY = !hb_valid;
  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = sh_valid & OUT_READY;
  assign sh_done  = (sh_rem == '0);
  // Shifter can take a new word this edge: empty, or its final slice is leaving.
  assign free     = !sh_valid | (out_fire & sh_done);

  // The output end of the shifter is fixed; data moves toward it, zero-filling behind.
  generate
    if (MSB_FIRST) begin : g_msb
      assign cur_slice  = sh_data[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];
      assign sh_shifted = sh_data << DATA_OUT_WIDTH;
    end else begin : g_lsb
      assign cur_slice  = sh_data[DATA_OUT_WIDTH-1:0];
      assign sh_shifted = sh_data >> DATA_OUT_WIDTH;
    end
  endgenerate

  assign OUT_VALID = sh_valid;
  assign OUT_DATA  = sh_valid ? cur_slice : '0;
  assign OUT_LAST  = sh_valid & sh_last & sh_done;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_data  <= '0;
      sh_rem   <= '0;
      sh_last  <= 1'b0;
      sh_valid <= 1'b0;
      hb_data  <= '0;
      hb_num   <= '0;
      hb_last  <= 1'b0;
      hb_valid <= 1'b0;
    end else begin
      if (out_fire && !sh_done) begin
        sh_data <= sh_shifted;
        sh_rem  <= sh_rem - CNT_W'(1);
      end else if (free) begin
        if (hb_valid) begin
          // Buffered word goes first; IN_READY is low so no IN fire can collide.
          sh_data  <= hb_data;
          sh_rem   <= hb_num;
          sh_last  <= hb_last;
          sh_valid <= 1'b1;
          hb_valid <= 1'b0;
        end else if (in_fire) begin
          // Direct path keeps single-slice words at one per cycle.
          sh_data  <= IN_DATA;
          sh_rem   <= IN_NUM;
          sh_last  <= IN_LAST;
          sh_valid <= 1'b1;
        end else begin
          sh_valid <= 1'b0;
        end
      end

      if (!free && in_fire) begin
        hb_data  <= IN_DATA;
        hb_num   <= IN_NUM;
        hb_last  <= IN_LAST;
        hb_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: an LSB-first and an MSB-first instance (64/16) share clock and reset.
// Each accepted word is expanded into its expected slices in a queue; every OUT fire is
// checked against that queue, and the scenario tasks add cycle-exact checks of their own.
module tb_piso_stream;
  localparam int DI = 64;
  localparam int DO = 16;
  localparam int NW = DI / DO;
  localparam int CW = $clog2(NW);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [DI-1:0] a_in_data;
  logic [CW-1:0] a_in_num;
  logic [DO-1:0] a_out_data;
  logic          b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [DI-1:0] b_in_data;
  logic [CW-1:0] b_in_num;
  logic [DO-1:0] b_out_data;

  piso_stream #(.DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(clk), .RESET_N(rst_n),
    .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_DATA(a_in_data),
    .IN_NUM(a_in_num), .IN_LAST(a_in_last),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_DATA(a_out_data), .OUT_LAST(a_out_last)
  );

  piso_stream #(.DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(clk), .RESET_N(rst_n),
    .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_DATA(b_in_data),
    .IN_NUM(b_in_num), .IN_LAST(b_in_last),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_DATA(b_out_data), .OUT_LAST(b_out_last)
  );

  int checks = 0;
  int failures = 0;

  // Expected output stream per instance: {last, slice}.
  logic [DO:0] qa[$];
  logic [DO:0] qb[$];

  // Reference: a word with count n yields slices 0..n taken from the chosen end;
  // only the final slice of a LAST word carries LAST.
  function automatic void push_model(input bit msb, input logic [DI-1:0] d,
                                     input logic [CW-1:0] n, input logic l);
    logic [DO-1:0] s;
    logic          sl;
    for (int k = 0; k <= int'(n); k++) begin
      s  = msb ? d[(NW-1-k)*DO +: DO] : d[k*DO +: DO];
      sl = l && (k == int'(n));
      if (msb) qb.push_back({sl, s});
      else     qa.push_back({sl, s});
    end
  endfunction

  always @(negedge clk) begin : mon_a
    logic [DO:0] e;
    if (rst_n) begin
      if (a_in_valid && a_in_ready) push_model(1'b0, a_in_data, a_in_num, a_in_last);
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL lsb_unexpected_slice: got data=%h last=%b, required no output", a_out_data, a_out_last);
        end else begin
          e = qa.pop_front();
          if ({a_out_last, a_out_data} !== e) begin
            failures++;
            $display("FAIL lsb_stream: got last=%b data=%h, required last=%b data=%h",
                     a_out_last, a_out_data, e[DO], e[DO-1:0]);
          end
        end
      end
      if (!a_out_valid) begin
        checks++;
        if ({a_out_last, a_out_data} !== '0) begin
          failures++;
          $display("FAIL lsb_idle_zero: got last=%b data=%h, required 0/0", a_out_last, a_out_data);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [DO:0] e;
    if (rst_n) begin
      if (b_in_valid && b_in_ready) push_model(1'b1, b_in_data, b_in_num, b_in_last);
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL msb_unexpected_slice: got data=%h last=%b, required no output", b_out_data, b_out_last);
        end else begin
          e = qb.pop_front();
          if ({b_out_last, b_out_data} !== e) begin
            failures++;
            $display("FAIL msb_stream: got last=%b data=%h, required last=%b data=%h",
                     b_out_last, b_out_data, e[DO], e[DO-1:0]);
          end
        end
      end
      if (!b_out_valid) begin
        checks++;
        if ({b_out_last, b_out_data} !== '0) begin
          failures++;
          $display("FAIL msb_idle_zero: got last=%b data=%h, required 0/0", b_out_last, b_out_data);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_num = '0; a_in_last = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_num = '0; b_in_last = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_out_valid, a_out_last, a_out_data, a_in_ready, b_out_valid, b_out_last, b_out_data, b_in_ready}
        !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_held: got lsb v=%b l=%b d=%h r=%b msb v=%b l=%b d=%h r=%b, required 0/0/0000/1 each",
               a_out_valid, a_out_last, a_out_data, a_in_ready, b_out_valid, b_out_last, b_out_data, b_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_out_valid, a_out_last, a_out_data, a_in_ready, b_out_valid, b_out_last, b_out_data, b_in_ready}
        !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_cycle: got lsb v=%b d=%h r=%b msb v=%b d=%h r=%b, required 0/0000/1 each",
               a_out_valid, a_out_data, a_in_ready, b_out_valid, b_out_data, b_in_ready);
    end
  endtask

  task automatic test_lsb_full();
    logic [DI-1:0] w;
    logic [DO-1:0] exp_s [NW];
    w = 64'h4444_3333_2222_1111;
    exp_s[0] = 16'h1111; exp_s[1] = 16'h2222; exp_s[2] = 16'h3333; exp_s[3] = 16'h4444;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = w; a_in_num = 2'd3; a_in_last = 1; a_out_ready = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (k < NW) begin
        if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, (k == NW-1), exp_s[k]}) begin
          failures++;
          $display("FAIL lsb_full_slice%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                   k, a_out_valid, a_out_last, a_out_data, (k == NW-1), exp_s[k]);
        end
      end else if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL lsb_full_after: got v=%b, required v=0", a_out_valid);
      end
    end
  endtask

  task automatic test_msb_partial();
    @(posedge clk); #1;
    b_in_valid = 1; b_in_data = 64'h4444_3333_2222_1111; b_in_num = 2'd1; b_in_last = 1; b_out_ready = 1;
    @(posedge clk); #1;
    b_in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (k == 0 && {b_out_valid, b_out_last, b_out_data} !== {1'b1, 1'b0, 16'h4444}) begin
        failures++;
        $display("FAIL msb_partial_s0: got v=%b l=%b d=%h, required v=1 l=0 d=4444", b_out_valid, b_out_last, b_out_data);
      end else if (k == 1 && {b_out_valid, b_out_last, b_out_data} !== {1'b1, 1'b1, 16'h3333}) begin
        failures++;
        $display("FAIL msb_partial_s1: got v=%b l=%b d=%h, required v=1 l=1 d=3333", b_out_valid, b_out_last, b_out_data);
      end else if (k >= 2 && b_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL msb_partial_extra: got v=%b d=%h, required v=0", b_out_valid, b_out_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DI-1:0] words [2];
    int got = 0;
    int sent = 0;
    int rdy_low = 0;
    bit fire;
    words[0] = 64'h000D_000C_000B_000A;
    words[1] = 64'h001D_001C_001B_001A;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = words[0]; a_in_num = 2'd3; a_in_last = 0; a_out_ready = 1;
    for (int c = 0; c < 20 && got < 2*NW; c++) begin
      @(negedge clk);
      fire = a_in_valid && a_in_ready;
      if (!a_in_ready) begin
        rdy_low++;
        checks++;
        if (a_out_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready_low_idle: got out_valid=%b while in_ready=0, required 1", a_out_valid);
        end
      end
      if (a_out_valid) begin
        checks++;
        if ({a_out_last, a_out_data} !== {(got == 2*NW-1), words[got/NW][(got%NW)*DO +: DO]}) begin
          failures++;
          $display("FAIL b2b_slice%0d: got l=%b d=%h, required l=%b d=%h", got, a_out_last, a_out_data,
                   (got == 2*NW-1), words[got/NW][(got%NW)*DO +: DO]);
        end
        got++;
      end else if (got > 0) begin
        checks++;
        failures++;
        $display("FAIL b2b_bubble: got out_valid=0 after %0d slices, required 1", got);
      end
      if (got < 2*NW) begin
        @(posedge clk); #1;
        if (fire) begin
          sent++;
          if (sent == 1) begin a_in_data = words[1]; a_in_last = 1; end
          else a_in_valid = 0;
        end
      end
    end
    checks++;
    if (got !== 2*NW) begin
      failures++;
      $display("FAIL b2b_count: got %0d slices, required %0d", got, 2*NW);
    end
    checks++;
    if (rdy_low !== NW-1) begin
      failures++;
      $display("FAIL b2b_ready_low_cycles: got %0d, required %0d", rdy_low, NW-1);
    end
    a_in_valid = 0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end_idle: got v=%b, required 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [DI-1:0] w1, w2, w3;
    int fires = 0;
    bit fire;
    bit w3_sent = 0;
    w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom}; w3 = {$urandom, $urandom};
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = w1; a_in_num = 2'd3; a_in_last = 1; a_out_ready = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(posedge clk); #1;
    // second slice of w1 is now on OUT; stall and offer two more words
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = w2; a_in_num = CW'($urandom_range(0, NW-1)); a_in_last = 1'($urandom_range(0, 1));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      fire = a_in_valid && a_in_ready;
      checks++;
      if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, 1'b0, w1[2*DO-1:DO]}) begin
        failures++;
        $display("FAIL bp_frozen_c%0d: got v=%b l=%b d=%h, required v=1 l=0 d=%h",
                 c, a_out_valid, a_out_last, a_out_data, w1[2*DO-1:DO]);
      end
      @(posedge clk); #1;
      if (fire) begin
        fires++;
        a_in_data = w3; a_in_num = CW'($urandom_range(0, NW-1)); a_in_last = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (fires !== 1 || a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_absorb: got fires=%0d in_ready=%b, required fires=1 in_ready=0", fires, a_in_ready);
    end
    a_out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fire = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (fire) begin a_in_valid = 0; w3_sent = 1; break; end
    end
    checks++;
    if (w3_sent !== 1'b1) begin
      failures++;
      $display("FAIL bp_third_word: got accepted=%b, required 1", w3_sent);
    end
    for (int c = 0; c < 50 && qa.size() != 0; c++) @(negedge clk);
    checks++;
    if (qa.size() !== 0) begin
      failures++;
      $display("FAIL bp_drain: got %0d slices outstanding, required 0", qa.size());
    end
  endtask

  task automatic test_single_slice();
    logic [DI-1:0] ws [10];
    logic          ls [10];
    for (int i = 0; i < 10; i++) begin
      ws[i] = {$urandom, $urandom};
      ls[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    a_out_ready = 1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        a_in_valid = 1; a_in_data = ws[i]; a_in_num = '0; a_in_last = ls[i];
      end else begin
        a_in_valid = 0;
      end
      @(negedge clk);
      if (i < 10) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL single_ready_w%0d: got in_ready=%b, required 1", i, a_in_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, ls[i-1], ws[i-1][DO-1:0]}) begin
          failures++;
          $display("FAIL single_out_w%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                   i-1, a_out_valid, a_out_last, a_out_data, ls[i-1], ws[i-1][DO-1:0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_msb();
    int sent = 0;
    bit fire;
    @(posedge clk); #1;
    for (int c = 0; c < 600 && sent < 40; c++) begin
      @(negedge clk);
      fire = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (fire) sent++;
      if (fire || !b_in_valid) begin
        if (sent < 40 && $urandom_range(0, 9) < 7) begin
          b_in_valid = 1; b_in_data = {$urandom, $urandom};
          b_in_num = CW'($urandom_range(0, NW-1)); b_in_last = 1'($urandom_range(0, 1));
        end else begin
          b_in_valid = 0;
        end
      end
      b_out_ready = ($urandom_range(0, 9) < 7);
    end
    b_in_valid = 0;
    b_out_ready = 1;
    for (int c = 0; c < 50 && qb.size() != 0; c++) @(negedge clk);
    checks++;
    if (sent !== 40 || qb.size() !== 0) begin
      failures++;
      $display("FAIL random_msb: got sent=%0d outstanding=%0d, required 40/0", sent, qb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [DI-1:0] w1, w2, w3;
    w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom}; w3 = {$urandom, $urandom};
    @(posedge clk); #1;
    a_out_ready = 1;
    a_in_valid = 1; a_in_data = w1; a_in_num = 2'd3; a_in_last = 1;
    @(posedge clk); #1;
    a_in_data = w2; a_in_last = 0;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, w1[2*DO-1:DO], 1'b0}) begin
      failures++;
      $display("FAIL rstmid_setup: got v=%b d=%h in_ready=%b, required v=1 d=%h in_ready=0",
               a_out_valid, a_out_data, a_in_ready, w1[2*DO-1:DO]);
    end
    #2;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    checks++;
    if ({a_out_valid, a_out_last, a_out_data, a_in_ready, b_out_valid, b_in_ready}
        !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_cleared: got v=%b l=%b d=%h in_ready=%b msb v=%b r=%b, required 0/0/0000/1 0/1",
               a_out_valid, a_out_last, a_out_data, a_in_ready, b_out_valid, b_in_ready);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = w3; a_in_num = CW'($urandom_range(0, NW-1)); a_in_last = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_data} !== {1'b1, w3[DO-1:0]}) begin
      failures++;
      $display("FAIL rstmid_new_first: got v=%b d=%h, required v=1 d=%h", a_out_valid, a_out_data, w3[DO-1:0]);
    end
    for (int c = 0; c < 20 && qa.size() != 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() !== 0 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drain: got outstanding=%0d v=%b, required 0/0", qa.size(), a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_full();
    test_msb_partial();
    test_back_to_back();
    test_backpressure();
    test_single_slice();
    test_random_msb();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (qa.size() !== 0 || qb.size() !== 0) begin
      failures++;
      $display("FAIL final_queues: got lsb=%0d msb=%0d outstanding, required 0/0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
